// File: rtl/fetch_stage.sv
// Instruction fetch stage for the RV64 core.
// Owns the PC, presents it to the instruction memory, and registers the
// returned word (or a fetch exception) into the IF/ID packet for decode.
// After a fetch exception, fetching stops until a trap redirects the PC.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        trap_en,
  input  logic [63:0] trap_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_exc_en,
  output logic [3:0]  id_exc_code,
  output logic [63:0] id_exc_val
);

  // state       | meaning
  // ST_RUN      | normal fetch, one packet per accepted cycle
  // ST_FAULT_WAIT | faulting packet issued; fetch frozen until trap_en
  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_FAULT_WAIT = 1'b1;

  localparam logic [3:0] CODE_MISALIGNED = 4'd0;

  logic [0:0]  state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [63:0] id_pc_nxt;
  logic [31:0] id_instr_nxt;
  logic        id_exc_en_nxt;
  logic [3:0]  id_exc_code_nxt;
  logic [63:0] id_exc_val_nxt;

  logic        running;
  logic        adv;
  logic        flush;
  logic [63:0] flush_pc;
  logic        misaligned;
  logic        fetch_fault;
  logic [3:0]  fault_code;
  logic [63:0] fault_val;

  assign pc_addr = pc;

  // Decode of the current cycle's control conditions.
  always_comb begin
    running     = (state == ST_RUN);
    adv         = running && (!id_valid || id_ready);
    // Redirects are meaningless while frozen on a fault; only a trap exits.
    flush       = trap_en || (redirect_en && running);
    flush_pc    = trap_en ? trap_pc : redirect_pc;
    misaligned  = (pc[1:0] != 2'b00);
    fetch_fault = misaligned || imem_exc_en;
    // Misalignment is detected locally and outranks any memory fault.
    fault_code  = misaligned ? CODE_MISALIGNED : imem_exc_code;
    fault_val   = misaligned ? pc : imem_exc_val;
  end

  // Next-state selection in priority order: flush, advance, hold.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    valid_nxt       = id_valid;
    id_pc_nxt       = id_pc;
    id_instr_nxt    = id_instr;
    id_exc_en_nxt   = id_exc_en;
    id_exc_code_nxt = id_exc_code;
    id_exc_val_nxt  = id_exc_val;

    if (flush) begin
      pc_nxt        = flush_pc;
      valid_nxt     = 1'b0;
      id_instr_nxt  = NOP_INSTR;
      id_exc_en_nxt = 1'b0;
      state_nxt     = ST_RUN;
    end else if (adv) begin
      valid_nxt = 1'b1;
      id_pc_nxt = pc;
      if (fetch_fault) begin
        id_instr_nxt    = NOP_INSTR;
        id_exc_en_nxt   = 1'b1;
        id_exc_code_nxt = fault_code;
        id_exc_val_nxt  = fault_val;
        state_nxt       = ST_FAULT_WAIT;
      end else begin
        id_instr_nxt    = instruction;
        id_exc_en_nxt   = 1'b0;
        id_exc_code_nxt = 4'd0;
        id_exc_val_nxt  = 64'd0;
        pc_nxt          = pc + 64'd4;
      end
    end else if (!running && id_valid && id_ready) begin
      // Faulting packet consumed; stay frozen with no packet outstanding.
      valid_nxt = 1'b0;
    end
  end

  // State, PC and IF/ID packet registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 64'd0;
      id_instr    <= NOP_INSTR;
      id_exc_en   <= 1'b0;
      id_exc_code <= 4'd0;
      id_exc_val  <= 64'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      id_valid    <= valid_nxt;
      id_pc       <= id_pc_nxt;
      id_instr    <= id_instr_nxt;
      id_exc_en   <= id_exc_en_nxt;
      id_exc_code <= id_exc_code_nxt;
      id_exc_val  <= id_exc_val_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table followed by
// randomized traffic compared against a packet-level reference model.
module tb_fetch_stage;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [63:0] pc_addr;
  logic [31:0] instruction;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        trap_en;
  logic [63:0] trap_pc;
  logic        id_ready;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;

  logic        use_hash;
  logic [31:0] tb_instr;

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [31:0] hash(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  // Instruction memory: either a directed word or a pseudo-random word per address.
  assign instruction = use_hash ? hash(pc_addr) : tb_instr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instruction(instruction),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .trap_en(trap_en), .trap_pc(trap_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_exc_en(id_exc_en), .id_exc_code(id_exc_code), .id_exc_val(id_exc_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst, trap, redir, ready, exc;
    logic [63:0] tpc, rpc, xval;
    logic [3:0]  xcode;
    logic [31:0] instr;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [63:0] e_id_pc;
    logic [31:0] e_instr;
    logic        e_exc;
    logic [3:0]  e_code;
    logic [63:0] e_val;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(
    input logic r, input logic t, input logic [63:0] tp, input logic rd, input logic [63:0] rp,
    input logic rdy, input logic x, input logic [3:0] xc, input logic [63:0] xv, input logic [31:0] in,
    input logic [63:0] epc, input logic ev, input logic [63:0] eip, input logic [31:0] ei,
    input logic ex, input logic [3:0] ec, input logic [63:0] eva);
    vec_t s;
    s.rst = r; s.trap = t; s.tpc = tp; s.redir = rd; s.rpc = rp; s.ready = rdy;
    s.exc = x; s.xcode = xc; s.xval = xv; s.instr = in;
    s.e_pc = epc; s.e_valid = ev; s.e_id_pc = eip; s.e_instr = ei;
    s.e_exc = ex; s.e_code = ec; s.e_val = eva;
    return s;
  endfunction

  // Reference model: the IF/ID packet and fetch pointer at packet level.
  typedef struct {
    logic [63:0] pc;
    logic        frozen;
    logic        valid;
    logic [63:0] ipc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] val;
  } mstate_t;

  mstate_t m, mn;

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n = s;
    if (rst) begin
      n.pc = RPC; n.frozen = 0; n.valid = 0; n.ipc = 0;
      n.instr = NOP; n.exc = 0; n.code = 0; n.val = 0;
    end else if (trap_en || (redirect_en && !s.frozen)) begin
      n.pc = trap_en ? trap_pc : redirect_pc;
      n.valid = 0; n.instr = NOP; n.exc = 0; n.frozen = 0;
    end else if (s.frozen) begin
      if (s.valid && id_ready) n.valid = 0;
    end else if (!s.valid || id_ready) begin
      n.valid = 1;
      n.ipc = s.pc;
      if (s.pc % 4 != 0) begin
        n.exc = 1; n.code = 0; n.val = s.pc; n.instr = NOP; n.frozen = 1;
      end else if (imem_exc_en) begin
        n.exc = 1; n.code = imem_exc_code; n.val = imem_exc_val; n.instr = NOP; n.frozen = 1;
      end else begin
        n.exc = 0; n.code = 0; n.val = 0; n.instr = hash(s.pc); n.pc = s.pc + 4;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(0, 7))
      0:       t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      1:       t = {$urandom, $urandom} & ~64'h3;
      default: t = RPC + 64'($urandom_range(0, 255) * 4);
    endcase
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    use_hash = 0; tb_instr = NOP;
    rst = 1; trap_en = 0; trap_pc = 0; redirect_en = 0; redirect_pc = 0;
    id_ready = 1; imem_exc_en = 0; imem_exc_code = 0; imem_exc_val = 0;

    //        rst t tpc                    rd rpc                 rdy x  xc xval        instr          | e_pc                   ev e_id_pc                e_instr        ex ec e_val
    vt.push_back(v(1, 0, 0,                 0, 0,                 1, 0, 0, 0,          0,             RPC,                   0, 0,                     NOP,           0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00500093,  RPC+4,                 1, RPC,                   32'h00500093,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00108113,  RPC+8,                 1, RPC+4,                 32'h00108113,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 0, 0, 0,          32'h00000513,  RPC+8,                 1, RPC+4,                 32'h00108113,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 1, 1, 64'h77,     32'h00000513,  RPC+8,                 1, RPC+4,                 32'h00108113,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 0, 0, 0,          32'h00000513,  RPC+8,                 1, RPC+4,                 32'h00108113,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00000513,  RPC+12,                1, RPC+8,                 32'h00000513,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 1, RPC+64'h100,       0, 0, 0, 0,          32'h00000613,  RPC+64'h100,           0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00a00593,  RPC+64'h104,           1, RPC+64'h100,           32'h00a00593,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 1, RPC+64'h102,       1, 0, 0, 0,          32'h00000713,  RPC+64'h102,           0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 0, 0, 0,          32'h12345678,  RPC+64'h102,           1, RPC+64'h102,           NOP,           1, 0, RPC+64'h102));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 0, 0, 0,          32'h12345678,  RPC+64'h102,           1, RPC+64'h102,           NOP,           1, 0, RPC+64'h102));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h12345678,  RPC+64'h102,           0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 1, 1, 64'h5,      32'h00000055,  RPC+64'h102,           0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 1, RPC+64'h200,       1, 0, 0, 0,          32'h00000055,  RPC+64'h102,           0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 1, RPC+4,             0, 0,                 1, 0, 0, 0,          32'h00000055,  RPC+4,                 0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00108113,  RPC+8,                 1, RPC+4,                 32'h00108113,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 1, 64'h80002000,      0, 0, 0, 0,          32'h00000013,  64'h80002000,          0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 1, 1, 64'h80002000, 32'hdeadbeef, 64'h80002000,          1, 64'h80002000,          NOP,           1, 1, 64'h80002000));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 0, 0, 0,          32'h00000093,  64'h80002000,          1, 64'h80002000,          NOP,           1, 1, 64'h80002000));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00000093,  64'h80002000,          0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 1, 64'h80000040,      1, 64'h80000080,      1, 0, 0, 0,          32'h00000093,  64'h80000040,          0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00200113,  64'h80000044,          1, 64'h80000040,          32'h00200113,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 1, 64'h80000082,      1, 0, 0, 0,          32'h00200113,  64'h80000082,          0, 0,                     0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 1, 1, 64'hABCD,   32'h00000001,  64'h80000082,          1, 64'h80000082,          NOP,           1, 0, 64'h80000082));
    vt.push_back(v(1, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00000001,  RPC,                   0, 0,                     NOP,           0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00500093,  RPC+4,                 1, RPC,                   32'h00500093,  0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 0, 0, 0, 0,          32'h00108113,  RPC+4,                 1, RPC,                   32'h00500093,  0, 0, 0));
    vt.push_back(v(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,           0, 0, 0, 0,          32'h00108113,  64'hFFFF_FFFF_FFFF_FFFC, 0, 0,                   0,             0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h00000073,  64'h0,                 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00000073, 0, 0, 0));
    vt.push_back(v(0, 0, 0,                 0, 0,                 1, 0, 0, 0,          32'h11111111,  64'h4,                 1, 64'h0,                 32'h11111111,  0, 0, 0));

    // Directed table: one edge per row, outputs checked just after it.
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; trap_en = vt[i].trap; trap_pc = vt[i].tpc;
      redirect_en = vt[i].redir; redirect_pc = vt[i].rpc; id_ready = vt[i].ready;
      imem_exc_en = vt[i].exc; imem_exc_code = vt[i].xcode; imem_exc_val = vt[i].xval;
      tb_instr = vt[i].instr;
      @(posedge clk); #1;
      check($sformatf("vec%0d pc_addr", i), pc_addr, vt[i].e_pc);
      check($sformatf("vec%0d id_valid", i), 64'(id_valid), 64'(vt[i].e_valid));
      if (vt[i].e_valid || vt[i].rst) begin
        check($sformatf("vec%0d id_pc", i), id_pc, vt[i].e_id_pc);
        check($sformatf("vec%0d id_instr", i), 64'(id_instr), 64'(vt[i].e_instr));
        check($sformatf("vec%0d id_exc_en", i), 64'(id_exc_en), 64'(vt[i].e_exc));
        check($sformatf("vec%0d id_exc_code", i), 64'(id_exc_code), 64'(vt[i].e_code));
        check($sformatf("vec%0d id_exc_val", i), id_exc_val, vt[i].e_val);
      end
    end

    // Randomized traffic against the reference model.
    use_hash = 1;
    m = '{pc: RPC, frozen: 0, valid: 0, ipc: 0, instr: NOP, exc: 0, code: 0, val: 0};
    for (int c = 0; c < 3000; c++) begin
      rst           = (c == 0) || ($urandom_range(0, 199) == 0);
      trap_en       = ($urandom_range(0, 19) == 0);
      trap_pc       = rand_target();
      redirect_en   = ($urandom_range(0, 9) == 0);
      redirect_pc   = rand_target();
      id_ready      = ($urandom_range(0, 3) != 0);
      imem_exc_en   = ($urandom_range(0, 11) == 0);
      imem_exc_code = 4'($urandom_range(0, 15));
      imem_exc_val  = {$urandom, $urandom};
      mn = model_next(m);
      @(posedge clk); #1;
      m = mn;
      check("rnd pc_addr", pc_addr, m.pc);
      check("rnd id_valid", 64'(id_valid), 64'(m.valid));
      if (m.valid) begin
        check("rnd id_pc", id_pc, m.ipc);
        check("rnd id_instr", 64'(id_instr), 64'(m.instr));
        check("rnd id_exc_en", 64'(id_exc_en), 64'(m.exc));
        check("rnd id_exc_code", 64'(id_exc_code), 64'(m.code));
        check("rnd id_exc_val", id_exc_val, m.val);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
